sorted_hex_display: RTL and testbench

- Downstream stage of the bubble sorter.
- Captures the four sorted 4-bit results and their display-enable flag.
- Drives a 4-digit, common-anode, multiplexed 7-segment display: one digit per scan slot, each value decoded as a hex glyph.
- Shadow registers update only at frame boundaries, so a re-sort never tears a frame.

---
 rtl/sorted_hex_display_if.sv | 50 +++++
 rtl/sorted_hex_display.sv | 160 ++++++++++++++++
 tb/tb_sorted_hex_display.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sorted_hex_display_if.sv
// ---------------------------------------------------------------------------
// sorted_hex_display_if
//
// Purpose:
//   Bundles the signals between the bubble sorter (and whoever observes the
//   display) and the sorted_hex_display stage into one interface.
//
// Signals:
//   sort_num0..3   4-bit sorted values, smallest in sort_num0
//   start_display  level, high while the sorted values are valid
//   an             4-bit digit anodes, active-low
//   seg            7-bit segments {g,f,e,d,c,b,a}, active-low
//   frame_done     one-cycle pulse at each frame boundary
//
// Modports:
//   master  producer side: drives the values, observes the display outputs
//   slave   display stage: consumes the values, drives the display outputs
// ---------------------------------------------------------------------------
interface sorted_hex_display_if;
    logic [3:0] sort_num0;
    logic [3:0] sort_num1;
    logic [3:0] sort_num2;
    logic [3:0] sort_num3;
    logic       start_display;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_done;

    modport master (
        output sort_num0,
        output sort_num1,
        output sort_num2,
        output sort_num3,
        output start_display,
        input  an,
        input  seg,
        input  frame_done
    );

    modport slave (
        input  sort_num0,
        input  sort_num1,
        input  sort_num2,
        input  sort_num3,
        input  start_display,
        output an,
        output seg,
        output frame_done
    );
endinterface

// File: rtl/sorted_hex_display.sv
// ---------------------------------------------------------------------------
// sorted_hex_display
//
// Purpose:
//   Downstream stage of the bubble sorter. Captures the four sorted 4-bit
//   results into shadow registers and scans them onto a 4-digit,
//   common-anode, multiplexed 7-segment display as hex glyphs. Shadows are
//   only refreshed at frame boundaries, so a re-sort never tears a frame.
//
// Parameters:
//   CLK_DIV    clk cycles per digit scan slot (>= 2, and >= BLANK_CYC+1 when
//              blanking is compiled in)
//   BLANK_CYC  anode-off cycles at the start of each slot (blanking only)
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   sorted_hex_display_if.slave
//           sort_num0..3, start_display in; an, seg, frame_done out
//
// Build option:
//   SCAN_BLANK_EN  when defined, the anodes are forced off during the first
//                  BLANK_CYC cycles of every displayed slot (anti-ghosting).
//                  When undefined, anodes switch directly between digits.
// ---------------------------------------------------------------------------
module sorted_hex_display #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    sorted_hex_display_if.slave bus
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W:0]   BLANK_LIM = (DIV_W + 1)'(BLANK_CYC);

`ifdef SCAN_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    // Active-low hex glyphs for a common-anode display, bit order {g..a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'h40;
            4'h1:    pattern = 7'h79;
            4'h2:    pattern = 7'h24;
            4'h3:    pattern = 7'h30;
            4'h4:    pattern = 7'h19;
            4'h5:    pattern = 7'h12;
            4'h6:    pattern = 7'h02;
            4'h7:    pattern = 7'h78;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h10;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h03;
            4'hC:    pattern = 7'h46;
            4'hD:    pattern = 7'h21;
            4'hE:    pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic             valid_q, valid_d;
    logic [3:0]       shadow_q [4];
    logic [3:0]       shadow_d [4];
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             frame_done_q, frame_done_d;

    logic tick;
    logic frame_boundary;
    logic load;
    logic blank_win;

    // Scan timing: the prescaler produces one tick per slot, the digit index
    // steps on that tick, and the last tick of digit 3 closes the frame.
    always_comb begin
        tick           = (div_cnt_q == DIV_LAST);
        frame_boundary = tick && (digit_q == 2'd3);

        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        digit_d   = tick ? digit_q + 2'd1 : digit_q;

        frame_done_d = frame_boundary;
    end

    // Capture: the very first valid set of values is taken immediately so
    // the display lights up without waiting a frame; after that, new values
    // are only accepted at a frame boundary so a frame is never mixed.
    // Dropping start_display simply freezes the shadows.
    always_comb begin
        load    = bus.start_display && (!valid_q || frame_boundary);
        valid_d = valid_q || bus.start_display;
        for (int k = 0; k < 4; k++) begin
            shadow_d[k] = shadow_q[k];
        end
        if (load) begin
            shadow_d[0] = bus.sort_num0;
            shadow_d[1] = bus.sort_num1;
            shadow_d[2] = bus.sort_num2;
            shadow_d[3] = bus.sort_num3;
        end
    end

    // Output drive, registered one cycle behind the digit index. The blank
    // window is judged on the pre-register count, so it lines up with the
    // first BLANK_CYC cycles in which the new digit is actually on the pins.
    // seg keeps the new pattern during blanking so it settles before the
    // anode turns on.
    always_comb begin
        blank_win = BLANK_ON && ({1'b0, div_cnt_q} < BLANK_LIM);
        an_d      = 4'hF;
        seg_d     = 7'h7F;
        if (valid_q) begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = hex_to_seg(shadow_q[digit_q]);
            if (blank_win) begin
                an_d = 4'hF;
            end
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            digit_q      <= 2'd0;
            valid_q      <= 1'b0;
            an_q         <= 4'hF;
            seg_q        <= 7'h7F;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                shadow_q[k] <= 4'h0;
            end
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_q      <= digit_d;
            valid_q      <= valid_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            for (int k = 0; k < 4; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sorted_hex_display.sv
// ---------------------------------------------------------------------------
// tb_sorted_hex_display
//
// Purpose:
//   Self-checking bench for sorted_hex_display with CLK_DIV=4, BLANK_CYC=1.
//   A reference model tracks the number of clocks since reset and derives the
//   scan position arithmetically, plus the captured values and valid flag.
//   Honours SCAN_BLANK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_sorted_hex_display;

    localparam int CLK_DIV   = 4;
    localparam int BLANK_CYC = 1;
    localparam int FRAME     = 4 * CLK_DIV;

    logic clk = 1'b0;
    logic rst;

    sorted_hex_display_if bus ();

    sorted_hex_display #(
        .CLK_DIV  (CLK_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         n_clk;
    bit         m_valid;
    logic [3:0] m_shadow [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fd;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic int cur_digit();
        return (n_clk / CLK_DIV) % 4;
    endfunction

    function automatic int cur_div();
        return n_clk % CLK_DIV;
    endfunction

    task automatic set_inputs(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        bus.sort_num0 = a;
        bus.sort_num1 = b;
        bus.sort_num2 = c;
        bus.sort_num3 = d;
    endtask

    // Advance one clock, update the model from the inputs seen at that edge,
    // then move 1 time unit past the edge for sampling/driving.
    task automatic step();
        int         dig;
        int         div;
        bit         boundary;
        logic [3:0] ins [4];
        @(posedge clk);
        ins[0] = bus.sort_num0;
        ins[1] = bus.sort_num1;
        ins[2] = bus.sort_num2;
        ins[3] = bus.sort_num3;
        if (rst) begin
            n_clk   = 0;
            m_valid = 1'b0;
            for (int k = 0; k < 4; k++) m_shadow[k] = 4'h0;
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_fd  = 1'b0;
        end else begin
            div      = n_clk % CLK_DIV;
            dig      = (n_clk / CLK_DIV) % 4;
            boundary = (n_clk % FRAME) == (FRAME - 1);
            if (m_valid) begin
                exp_an  = ~(4'b0001 << dig);
                exp_seg = glyph[m_shadow[dig]];
`ifdef SCAN_BLANK_EN
                if (div < BLANK_CYC) exp_an = 4'hF;
`endif
            end else begin
                exp_an  = 4'hF;
                exp_seg = 7'h7F;
            end
            exp_fd = boundary;
            if (bus.start_display && (!m_valid || boundary)) begin
                m_shadow = ins;
                m_valid  = 1'b1;
            end
            n_clk++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_display = 1'b1;
        set_inputs(4'h1, 4'h3, 4'h7, 4'hC);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.an !== 4'hF) begin
                errors++;
                $display("[TB] FAIL reset_an cyc=%0d got=%h want=F", i, bus.an);
            end
            checks++;
            if (bus.seg !== 7'h7F) begin
                errors++;
                $display("[TB] FAIL reset_seg cyc=%0d got=%h want=7F", i, bus.seg);
            end
            checks++;
            if (bus.frame_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_fd cyc=%0d got=%b want=0", i, bus.frame_done);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.an !== 4'hF) begin
            errors++;
            $display("[TB] FAIL load_blank_an got=%h want=F", bus.an);
        end
        step();
        checks++;
        if (bus.seg !== 7'h79) begin
            errors++;
            $display("[TB] FAIL first_digit_seg got=%h want=79", bus.seg);
        end
        checks++;
        if (bus.an !== exp_an) begin
            errors++;
            $display("[TB] FAIL first_digit_an got=%h want=%h", bus.an, exp_an);
        end
    endtask

    task automatic test_basic_scan();
        int pulses = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (bus.frame_done === 1'b1) pulses++;
            checks++;
            if (bus.an !== exp_an || bus.seg !== exp_seg || bus.frame_done !== exp_fd) begin
                errors++;
                $display("[TB] FAIL basic_scan cyc=%0d an/seg/fd got=%h/%h/%b want=%h/%h/%b",
                         i, bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("[TB] FAIL frame_done_count got=%0d want=2", pulses);
        end
    endtask

    task automatic test_tear_free();
        int guard = 0;
        int early_new = 0;
        while (cur_digit() != 1 && guard < FRAME) begin
            step();
            guard++;
        end
        set_inputs(4'h0, 4'h2, 4'hA, 4'hF);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (i < 2 * CLK_DIV && (bus.seg === 7'h24 || bus.seg === 7'h08 || bus.seg === 7'h0E))
                early_new++;
            checks++;
            if (bus.an !== exp_an || bus.seg !== exp_seg || bus.frame_done !== exp_fd) begin
                errors++;
                $display("[TB] FAIL tear_free cyc=%0d an/seg/fd got=%h/%h/%b want=%h/%h/%b",
                         i, bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
        end
        checks++;
        if (early_new != 0) begin
            errors++;
            $display("[TB] FAIL tear_free_early got=%0d want=0", early_new);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) step();
        bus.start_display = 1'b0;
        step();
        set_inputs(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            checks++;
            if (bus.an !== exp_an || bus.seg !== exp_seg || bus.frame_done !== exp_fd) begin
                errors++;
                $display("[TB] FAIL hold cyc=%0d an/seg/fd got=%h/%h/%b want=%h/%h/%b",
                         i, bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
        end
        bus.start_display = 1'b1;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (!(cur_digit() == 2 && cur_div() == 1) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
            errors++;
            $display("[TB] FAIL reset_mid an/seg got=%h/%h want=F/7F", bus.an, bus.seg);
        end
        rst = 1'b0;
        for (int i = 0; i < FRAME + 2; i++) begin
            step();
            checks++;
            if (bus.an !== exp_an || bus.seg !== exp_seg || bus.frame_done !== exp_fd) begin
                errors++;
                $display("[TB] FAIL reset_mid_resume cyc=%0d an/seg/fd got=%h/%h/%b want=%h/%h/%b",
                         i, bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
        end
    endtask

    task automatic test_load_on_tick();
        rst = 1'b1;
        bus.start_display = 1'b0;
        step();
        rst = 1'b0;
        set_inputs(4'h8, 4'h9, 4'hB, 4'hD);
        for (int i = 0; i < CLK_DIV - 1; i++) step();
        bus.start_display = 1'b1;
        for (int i = 0; i < FRAME + 4; i++) begin
            step();
            checks++;
            if (bus.an !== exp_an || bus.seg !== exp_seg || bus.frame_done !== exp_fd) begin
                errors++;
                $display("[TB] FAIL load_on_tick cyc=%0d an/seg/fd got=%h/%h/%b want=%h/%h/%b",
                         i, bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0)
                set_inputs(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            bus.start_display = ($urandom_range(5) != 0);
            rst = ($urandom_range(99) == 0);
            step();
            checks++;
            if (bus.an !== exp_an || bus.seg !== exp_seg || bus.frame_done !== exp_fd) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d an/seg/fd got=%h/%h/%b want=%h/%h/%b",
                         i, bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        bus.start_display = 1'b0;
        set_inputs(4'h0, 4'h0, 4'h0, 4'h0);
        n_clk   = 0;
        m_valid = 1'b0;
        for (int k = 0; k < 4; k++) m_shadow[k] = 4'h0;
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_fd  = 1'b0;

        test_reset();
        test_basic_scan();
        test_tear_free();
        test_hold();
        test_reset_mid();
        test_load_on_tick();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
